// File: rtl/aes_key_schedule_store.sv
// aes_key_schedule_store: AES-128 key expansion (one round per clock) into an 11-slot round-key store.
// Optional AES_KEY_INV_MIX_EN applies InvMixColumns to rounds 1..NR-1 on the read path.
module aes_key_schedule_store #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [KW-1:0]              key_in,
    input  logic                       key_load,
    output logic                       busy,
    output logic                       ready,
    output logic                       key_done,
    input  logic [$clog2(NR+1)-1:0]    rd_round,
    output logic [KW-1:0]              rd_key
);
    localparam int RW = $clog2(NR+1);
    localparam logic [RW-1:0] LAST = RW'(NR);
    localparam logic [7:0] RCON [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                          8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        state_q;
    logic [RW-1:0] cnt_q;
    logic [KW-1:0] slot_q [0:NR];
    logic          busy_q, ready_q, done_q;
    logic [KW-1:0] rd_key_q, rd_key_d, raw, prev, next_d;
    logic [RW-1:0] prev_idx;
    logic [31:0]   t, n0, n1, n2, n3;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the FIPS-197 affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s, r;
        s = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef AES_KEY_INV_MIX_EN
    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        logic [7:0]   a [4];
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = x[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                y[127-32*c-8*r -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                     ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        return y;
    endfunction
`endif

    always_comb begin
        prev_idx = (cnt_q == '0 || cnt_q > LAST) ? '0 : cnt_q - RW'(1);
        prev     = slot_q[prev_idx];
        t        = sub_word({prev[23:0], prev[31:24]}) ^ {RCON[cnt_q], 24'h0};
        n0       = prev[127:96] ^ t;
        n1       = prev[95:64] ^ n0;
        n2       = prev[63:32] ^ n1;
        n3       = prev[31:0] ^ n2;
        next_d   = {n0, n1, n2, n3};
        raw      = (rd_round > LAST) ? '0 : slot_q[rd_round];
`ifdef AES_KEY_INV_MIX_EN
        rd_key_d = (rd_round != '0 && rd_round < LAST) ? inv_mix(raw) : raw;
`else
        rd_key_d = raw;
`endif
    end

    // key_load restarts from any state, which also covers abort-while-busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            rd_key_q <= '0;
            for (int k = 0; k <= NR; k++) slot_q[k] <= '0;
        end else begin
            rd_key_q <= rd_key_d;
            done_q   <= 1'b0;
            if (key_load) begin
                slot_q[0] <= key_in;
                cnt_q     <= RW'(1);
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
                state_q   <= EXPAND;
            end else if (state_q == EXPAND) begin
                slot_q[cnt_q] <= next_d;
                cnt_q         <= cnt_q + RW'(1);
                if (cnt_q == LAST) begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign key_done = done_q;
    assign rd_key   = rd_key_q;
endmodule

// File: tb/tb_aes_key_schedule_store.sv
// tb_aes_key_schedule_store: directed + random checks of the key store against a FIPS-197 word-level model.
module tb_aes_key_schedule_store;
    logic         clk = 1'b0;
    logic         reset, key_load, busy, ready, key_done;
    logic [127:0] key_in, rd_key;
    logic [3:0]   rd_round;
    int           total = 0, bad = 0, done_cnt = 0;
    logic [7:0]   sb [0:255];
    logic [127:0] rk_m [0:10];

    aes_key_schedule_store dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load), .busy(busy),
        .ready(ready), .key_done(key_done), .rd_round(rd_round), .rd_key(rd_key)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (key_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S-box table generated by the classic generator/inverse walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tw;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int r = 0; r <= 10; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int k = 7; k >= 0; k--) begin
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            if (b[k]) p = p ^ a;
        end
        return p;
    endfunction

    function automatic logic [127:0] exp_lit(input int r, input logic [127:0] raw);
        logic [7:0]   m [0:15];
        logic [7:0]   acc;
        logic [127:0] y;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09, 8'h09, 8'h0e, 8'h0b, 8'h0d,
              8'h0d, 8'h09, 8'h0e, 8'h0b, 8'h0b, 8'h0d, 8'h09, 8'h0e};
        y = raw;
`ifdef AES_KEY_INV_MIX_EN
        if (r >= 1 && r <= 9)
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) begin
                    acc = '0;
                    for (int k = 0; k < 4; k++) acc = acc ^ gm(m[4*i+k], raw[127-32*c-8*k -: 8]);
                    y[127-32*c-8*i -: 8] = acc;
                end
`endif
        return (r > 10) ? 128'h0 : y;
    endfunction

    function automatic logic [127:0] exp_rd(input int r);
        return (r > 10) ? 128'h0 : exp_lit(r, rk_m[r]);
    endfunction

    task automatic rd(input int r, output logic [127:0] v);
        rd_round = 4'(r);
        @(negedge clk);
        v = rd_key;
    endtask

    task automatic load(input logic [127:0] key);
        key_in = key;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string tag);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b1;
        while (key_done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1 || ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'd10);
        chk({tag, "_busy_during"}, 128'(ok), 128'd1);
        chk({tag, "_busy_after"}, 128'(busy), 128'd0);
        chk({tag, "_ready_after"}, 128'(ready), 128'd1);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 128'(key_done), 128'd0);
    endtask

    task automatic sweep(input string tag);
        logic [127:0] v;
        for (int r = 10; r >= 0; r--) begin
            rd(r, v);
            chk($sformatf("%s_rd%0d", tag, r), v, exp_rd(r));
        end
        rd(11, v);
        chk({tag, "_rd11"}, v, 128'h0);
        rd(15, v);
        chk({tag, "_rd15"}, v, 128'h0);
    endtask

    initial begin
        logic [127:0] v, k;
        int           d0;
        build_sbox();
        reset = 1'b1;
        key_load = 1'b0;
        key_in = '0;
        rd_round = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ready", 128'(ready), 128'd0);
        chk("rst_done", 128'(key_done), 128'd0);
        for (int r = 0; r < 16; r++) begin
            rd(r, v);
            chk($sformatf("rst_rd%0d", r), v, 128'h0);
        end

        k = 128'h000102030405060708090a0b0c0d0e0f;
        model(k);
        load(k);
        wait_done("k0");
        rd(10, v); chk("k0_vec_r10", v, exp_lit(10, 128'h13111d7fe3944a17f307a78b4d2b30c5));
        rd(0, v);  chk("k0_vec_r0", v, k);
        sweep("k0");

        k = 128'h5468617473206d79204b756e67204675;
        model(k);
        load(k);
        chk("reload_ready_drop", 128'(ready), 128'd0);
        wait_done("k2");
        rd(1, v);  chk("k2_vec_r1", v, exp_lit(1, 128'he232fcf191129188b159e4e6d679a293));
        rd(10, v); chk("k2_vec_r10", v, exp_lit(10, 128'h28fddef86da4244accc0a4fe3b316f26));

        d0 = done_cnt;
        load(128'h000102030405060708090a0b0c0d0e0f);
        repeat (4) @(negedge clk);
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model(k);
        load(k);
        wait_done("abort");
        chk("abort_done_count", 128'(done_cnt - d0), 128'd1);
        rd(1, v);  chk("k1_vec_r1", v, exp_lit(1, 128'ha0fafe1788542cb123a339392a6c7605));
        rd(10, v); chk("k1_vec_r10", v, exp_lit(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        sweep("k1");

        for (int i = 0; i < 4; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model(k);
            load(k);
            wait_done($sformatf("rnd%0d", i));
            sweep($sformatf("rnd%0d", i));
        end

        d0 = done_cnt;
        load(k);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_ready", 128'(ready), 128'd0);
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
        rd(0, v);  chk("midrst_r0", v, 128'h0);
        rd(10, v); chk("midrst_r10", v, 128'h0);

        reset = 1'b1;
        key_load = 1'b1;
        key_in = k;
        @(negedge clk);
        reset = 1'b0;
        key_load = 1'b0;
        chk("rst_wins_busy", 128'(busy), 128'd0);
        repeat (12) @(negedge clk);
        chk("rst_wins_ready", 128'(ready), 128'd0);
        rd(0, v);  chk("rst_wins_r0", v, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
